// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared by the instruction fetch sequencer.
//   - opcode constants the sequencer reacts to (mul, div, halt)
//   - bit positions of the IR fields
//   - FSM state encoding
// Configuration macro: FETCH_MULDIV_STALL_EN adds the STALL state.
package fetch_pkg;

  localparam logic [4:0] OP_MUL  = 5'b01100;
  localparam logic [4:0] OP_DIV  = 5'b01101;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;
  localparam int DEST_MSB   = 26;
  localparam int DEST_LSB   = 23;
  localparam int RA_MSB     = 22;
  localparam int RA_LSB     = 19;
  localparam int RB_MSB     = 18;
  localparam int RB_LSB     = 15;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_ISSUE = 3'd2,
    S_HALT  = 3'd4
`ifdef FETCH_MULDIV_STALL_EN
    , S_STALL = 3'd3
`endif
  } state_e;

  function automatic logic [4:0] ir_opcode(input logic [31:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter register.
//   clk     in   system clock
//   clr     in   synchronous active-high clear (pc -> 0)
//   load    in   load pc_new (priority over inc)
//   inc     in   advance by one, wrapping modulo 2^ADDR_W
//   pc_new  in   load value
//   pc      out  current program counter
module pc_reg #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] pc_new,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = pc_new;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch and issue sequencer feeding the control
// unit's IR. Reads words from program memory (mem_rd/mem_ack), keeps the PC
// and offers each word on ir with an ir_valid/ir_ready handshake.
//   clk, clr            clock, synchronous active-high reset
//   run                 fetch enable, checked only when leaving a state
//   mem_addr/mem_rd     read request (mem_addr always equals pc)
//   mem_ack/mem_rdata   read completion with data in the same cycle
//   ir/ir_valid/ir_ready  instruction output handshake
//   pc_load/pc_new      redirect, priority over sequential fetch
//   pc                  address of the next word to fetch
//   halted              high while in HALT
// Configuration macro: FETCH_MULDIV_STALL_EN -- when defined, issuing a mul or
// div is followed by MULDIV_STALL idle cycles before the next request.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int MULDIV_STALL = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_new,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        discard_q, discard_d;  // the outstanding read belongs to a stale pc
  logic        mem_rd_q, mem_rd_d;
  logic        pc_inc;
  logic [4:0]  opcode;
  state_e      resume_state;

`ifdef FETCH_MULDIV_STALL_EN
  localparam int STALL_W = (MULDIV_STALL > 1) ? $clog2(MULDIV_STALL) : 1;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
`else
  logic unused_stall_cfg;
  assign unused_stall_cfg = (MULDIV_STALL != 0);
`endif

  pc_reg #(
    .ADDR_W(ADDR_W)
  ) u_pc_reg (
    .clk   (clk),
    .clr   (clr),
    .load  (pc_load),
    .inc   (pc_inc),
    .pc_new(pc_new),
    .pc    (pc)
  );

  assign opcode       = ir_opcode(ir_q);
  // A redirect always restarts fetching, even with run low.
  assign resume_state = (run || pc_load) ? S_REQ : S_IDLE;

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    discard_d = discard_q;
    pc_inc    = 1'b0;
`ifdef FETCH_MULDIV_STALL_EN
    stall_cnt_d = stall_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (run || pc_load) state_d = S_REQ;
      end
      S_REQ: begin
        if (mem_ack) begin
          if (discard_q || pc_load) begin
            // Stale word: drop it and request again at the (new) pc.
            discard_d = 1'b0;
          end else begin
            ir_d    = mem_rdata;
            pc_inc  = 1'b1;
            state_d = S_ISSUE;
          end
        end else if (pc_load) begin
          discard_d = 1'b1;
        end
      end
      S_ISSUE: begin
        if (ir_ready) begin
          if (opcode == OP_HALT) begin
            state_d = S_HALT;
`ifdef FETCH_MULDIV_STALL_EN
          end else if (is_muldiv(opcode) && (MULDIV_STALL > 0)) begin
            state_d     = S_STALL;
            stall_cnt_d = STALL_W'(MULDIV_STALL - 1);
`endif
          end else begin
            state_d = resume_state;
          end
        end else if (pc_load) begin
          state_d = S_REQ;
        end
      end
`ifdef FETCH_MULDIV_STALL_EN
      S_STALL: begin
        if (pc_load) begin
          state_d = S_REQ;
        end else if (stall_cnt_q == '0) begin
          state_d = resume_state;
        end else begin
          stall_cnt_d = stall_cnt_q - STALL_W'(1);
        end
      end
`endif
      S_HALT: begin
        if (pc_load) state_d = S_REQ;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    mem_rd_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      discard_q <= 1'b0;
      mem_rd_q  <= 1'b0;
`ifdef FETCH_MULDIV_STALL_EN
      stall_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      discard_q <= discard_d;
      mem_rd_q  <= mem_rd_d;
`ifdef FETCH_MULDIV_STALL_EN
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

  assign mem_addr = pc;
  assign mem_rd   = mem_rd_q;
  assign ir       = ir_q;
  assign ir_valid = (state_q == S_ISSUE);
  assign halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch. A memory model answers
// read requests; expected issued words go into a scoreboard queue and a
// monitor compares them at every ir handshake.
module tb_instr_fetch;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          clr, run, mem_rd, mem_ack, ir_valid, ir_ready, pc_load, halted;
  logic [AW-1:0] mem_addr, pc_new, pc;
  logic [31:0]   mem_rdata, ir;

  instr_fetch #(.ADDR_W(AW), .MULDIV_STALL(4)) dut (
    .clk(clk), .clr(clr), .run(run), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .pc_load(pc_load), .pc_new(pc_new), .pc(pc),
    .halted(halted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("[TB] ok %s = %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem [0:255];
  int          mem_lat   = 0;
  logic        force_ack = 1'b0;
  int          wait_cnt  = 0;
  logic [7:0]  req_addr  = 8'h00;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (force_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_0BAD;
      end else if (clr || !mem_rd) begin
        wait_cnt = 0;
      end else begin
        if (wait_cnt == 0) req_addr = mem_addr[7:0];
        if (wait_cnt >= mem_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[req_addr];
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // ---------------- scoreboard + monitor ----------------
  typedef struct {
    logic [31:0] data;
    int          cyc;   // -1: issue cycle not checked
  } exp_t;
  exp_t sb_q[$];

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ir_valid && ir_ready) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_issue: got ir %0h expected no issue (cycle %0d)", ir, cyc);
        end else begin
          e = sb_q.pop_front();
          check("issue_ir", 64'(ir), 64'(e.data));
          if (e.cyc >= 0) check("issue_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    sb_q.push_back(e);
  endtask

  task automatic wait_halted();
    for (int n = 0; n < 40 && !halted; n++) tick();
    check("halt_reached", 64'(halted), 64'd1);
  endtask

  int base;
  int gap;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h00] = 32'h0891_8000;  // add
    mem[8'h01] = 32'h1088_0000;  // sub
    mem[8'h02] = 32'hF800_0000;  // halt
    mem[8'h08] = 32'h1088_0000;
    mem[8'h09] = 32'hF800_0009;
    mem[8'h10] = 32'h6000_0000;  // mul
    mem[8'h11] = 32'hF800_0011;
    mem[8'h20] = 32'h2000_0001;  // must never be issued
    mem[8'h40] = 32'hF800_0040;
    mem[8'hFF] = 32'hF800_00FF;

    clr = 1'b1; run = 1'b0; ir_ready = 1'b0; pc_load = 1'b0; pc_new = '0;
    repeat (2) tick();
    check("rst_ir", 64'(ir), 64'h0);
    check("rst_ir_valid", 64'(ir_valid), 64'h0);
    check("rst_mem_rd", 64'(mem_rd), 64'h0);
    check("rst_pc", 64'(pc), 64'h0);
    check("rst_mem_addr", 64'(mem_addr), 64'h0);
    check("rst_halted", 64'(halted), 64'h0);

    // add, sub, halt at zero wait: issued on cycles 2, 4, 6
    clr = 1'b0;
    base = cyc;
    push(32'h0891_8000, base + 2);
    push(32'h1088_0000, base + 4);
    push(32'hF800_0000, base + 6);
    run = 1'b1; ir_ready = 1'b1;
    repeat (7) tick();
    check("t1_halted", 64'(halted), 64'd1);
    check("t1_pc", 64'(pc), 64'd3);
    check("t1_mem_rd", 64'(mem_rd), 64'd0);

    // leave HALT via pc_load = 8, then hold ir_ready low for 5 cycles
    ir_ready = 1'b0; pc_load = 1'b1; pc_new = 16'h0008;
    tick();
    pc_load = 1'b0;
    check("t2_halted_fell", 64'(halted), 64'd0);
    check("t2_mem_addr", 64'(mem_addr), 64'h8);
    check("t2_mem_rd", 64'(mem_rd), 64'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_ir", 64'(ir), 64'h1088_0000);
      check("t2_hold_valid", 64'(ir_valid), 64'd1);
      check("t2_hold_no_rd", 64'(mem_rd), 64'd0);
      check("t2_hold_pc", 64'(pc), 64'h9);
      tick();
    end
    push(32'h1088_0000, -1);
    push(32'hF800_0009, -1);
    ir_ready = 1'b1;
    wait_halted();

    // redirect to 0x40 while a 3-wait read of 0x20 is outstanding
    mem_lat = 3;
    pc_load = 1'b1; pc_new = 16'h0020;
    tick();
    pc_new = 16'h0040;
    tick();
    pc_load = 1'b0;
    check("t3_mem_addr", 64'(mem_addr), 64'h40);
    check("t3_mem_rd_held", 64'(mem_rd), 64'd1);
    repeat (3) tick();
    check("t3_addr_after_drop", 64'(mem_addr), 64'h40);
    check("t3_no_issue", 64'(ir_valid), 64'd0);
    push(32'hF800_0040, -1);
    wait_halted();
    mem_lat = 0;

    // mul: gap between its handshake and the next mem_rd
    pc_load = 1'b1; pc_new = 16'h0010;
    tick();
    pc_load = 1'b0;
    push(32'h6000_0000, -1);
    push(32'hF800_0011, -1);
    tick();
    gap = 0;
    tick();
    while (!mem_rd && gap < 20) begin
      gap++;
      tick();
    end
`ifdef FETCH_MULDIV_STALL_EN
    check("t4_muldiv_gap", 64'(gap), 64'd4);
`else
    check("t4_muldiv_gap", 64'(gap), 64'd0);
`endif
    wait_halted();

    // clr in the middle of a request, then a late ack
    run = 1'b0; mem_lat = 5;
    pc_load = 1'b1; pc_new = 16'h0030;
    tick();
    pc_load = 1'b0;
    check("t5_req_pending", 64'(mem_rd), 64'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0; force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    check("t5_ir", 64'(ir), 64'h0);
    check("t5_ir_valid", 64'(ir_valid), 64'd0);
    check("t5_pc", 64'(pc), 64'h0);
    check("t5_mem_addr", 64'(mem_addr), 64'h0);
    check("t5_mem_rd", 64'(mem_rd), 64'd0);
    check("t5_halted", 64'(halted), 64'd0);

    // pc wrap from all-ones
    mem_lat = 0; run = 1'b1;
    pc_load = 1'b1; pc_new = 16'hFFFF;
    tick();
    pc_load = 1'b0;
    check("t6_mem_addr", 64'(mem_addr), 64'hFFFF);
    push(32'hF800_00FF, -1);
    tick();
    check("t6_pc_wrap", 64'(pc), 64'h0);
    wait_halted();
    check("t6_pc_final", 64'(pc), 64'h0);

    repeat (2) tick();
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
